// File: rtl/klein_vec_feeder_if.sv
// Element stream into the Klein vector feeder: LANES elements per beat, valid/ready with last.
interface klein_vec_feeder_if #(
  parameter int LANES     = 4,
  parameter int BIT_WIDTH = 8
);
  logic                                s_valid_i;
  logic                                s_ready_o;
  logic [LANES-1:0][BIT_WIDTH-1:0]     s_data_i;
  logic                                s_last_i;

  modport master (output s_valid_i, s_data_i, s_last_i, input  s_ready_o);
  modport slave  (input  s_valid_i, s_data_i, s_last_i, output s_ready_o);
endinterface

// File: rtl/klein_vec_feeder.sv
// Assembles LANES-wide beats into a zero-padded ELEMS_COUNT vector for the Klein adder tree,
// strobes it for one cycle with an ID, and flags that ID when the tree's sum emerges.
module klein_vec_feeder #(
  parameter int EXP_WIDTH_I  = 5,
  parameter int MANT_WIDTH_I = 2,
  parameter int ELEMS_COUNT  = 32,
  parameter int LANES        = 4,
  parameter int TREE_LATENCY = 10,
  parameter int ID_WIDTH     = 4,
  localparam int BIT_WIDTH_I = 1 + EXP_WIDTH_I + MANT_WIDTH_I,
  localparam int BEATS       = ELEMS_COUNT / LANES
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  klein_vec_feeder_if.slave                       st,
  output logic [ELEMS_COUNT-1:0][BIT_WIDTH_I-1:0] vec_o,
  output logic                                    vec_valid_o,
  output logic [ID_WIDTH-1:0]                     vec_id_o,
  output logic                                    sum_valid_o,
  output logic [ID_WIDTH-1:0]                     sum_id_o
);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {FILL, ISSUE} state_t;

  state_t                                  state;
  logic [CNT_W-1:0]                        cnt;
  logic [ID_WIDTH-1:0]                     next_id;
  logic [ELEMS_COUNT-1:0][BIT_WIDTH_I-1:0] fill_buf;
  logic [ELEMS_COUNT-1:0][BIT_WIDTH_I-1:0] merged;
  logic                                    accept;
  logic                                    close;
  logic [TREE_LATENCY-1:0]                 vld_pipe;
  logic [TREE_LATENCY-1:0][ID_WIDTH-1:0]   id_pipe;

  assign st.s_ready_o = (state == FILL) && !rst_i;
  assign accept       = st.s_valid_i && st.s_ready_o;
  assign close        = accept && (st.s_last_i || cnt == CNT_W'(BEATS - 1));

  // Fill buffer with the current beat dropped into its slot group.
  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    assign merged[b*LANES +: LANES] = (cnt == CNT_W'(b)) ? st.s_data_i
                                                         : fill_buf[b*LANES +: LANES];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= FILL;
      cnt         <= '0;
      fill_buf    <= '0;
      vec_o       <= '0;
      vec_valid_o <= 1'b0;
      vec_id_o    <= '0;
      next_id     <= '0;
    end else begin
      vec_valid_o <= 1'b0;
      case (state)
        FILL: if (accept) begin
          if (close) begin
            vec_o       <= merged;
            vec_id_o    <= next_id;
            vec_valid_o <= 1'b1;
            fill_buf    <= '0;
            cnt         <= '0;
            state       <= ISSUE;
          end else begin
            fill_buf <= merged;
            cnt      <= cnt + 1'b1;
          end
        end
        ISSUE: begin
          state   <= FILL;
          next_id <= next_id + 1'b1;
        end
        default: state <= FILL;
      endcase
    end
  end

  // One slot per tree stage, so any number of vectors can be in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= TREE_LATENCY'({vld_pipe, vec_valid_o});
      id_pipe  <= (TREE_LATENCY*ID_WIDTH)'({id_pipe, vec_id_o});
    end
  end

  assign sum_valid_o = vld_pipe[TREE_LATENCY-1];
  assign sum_id_o    = id_pipe[TREE_LATENCY-1];
endmodule

// File: tb/tb_klein_vec_feeder.sv
// Bench for klein_vec_feeder: table-driven vectors, hand sequences and random traffic
// checked every cycle against a queue-based model of the feeder.
module tb_klein_vec_feeder;
  localparam int EXP_W = 5, MANT_W = 2, BW = 1 + EXP_W + MANT_W;
  localparam int ELEMS = 32, LANES = 4, BEATS = ELEMS / LANES;
  localparam int TL = 10, IDW = 4, VW = ELEMS * BW;

  typedef logic [LANES-1:0][BW-1:0] beat_t;
  typedef logic [ELEMS-1:0][BW-1:0] vec_t;
  typedef struct {
    int             nbeats;
    bit             use_last;
    bit             konst;
    logic [BW-1:0]  base;
    int             exp_live;
    logic [IDW-1:0] exp_id;
  } row_t;
  typedef struct {
    longint         due;
    logic [IDW-1:0] id;
  } pend_t;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  vec_t           vec_o;
  logic           vec_valid_o;
  logic [IDW-1:0] vec_id_o;
  logic           sum_valid_o;
  logic [IDW-1:0] sum_id_o;
  int             checks = 0;
  int             failures = 0;

  klein_vec_feeder_if #(.LANES(LANES), .BIT_WIDTH(BW)) st ();

  klein_vec_feeder #(
    .EXP_WIDTH_I(EXP_W), .MANT_WIDTH_I(MANT_W), .ELEMS_COUNT(ELEMS),
    .LANES(LANES), .TREE_LATENCY(TL), .ID_WIDTH(IDW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .st(st),
    .vec_o(vec_o), .vec_valid_o(vec_valid_o), .vec_id_o(vec_id_o),
    .sum_valid_o(sum_valid_o), .sum_id_o(sum_id_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Model: elements collected in a queue; a vector closes on last or when full,
  // the next cycle is the issue bubble, and its sum is due TL cycles after that.
  longint         cyc = 0;
  bit             started = 0, m_bubble = 0, m_acc = 0;
  logic [BW-1:0]  part[$];
  vec_t           m_vec = '0;
  logic [IDW-1:0] m_vid = '0, m_next = '0;
  pend_t          sumq[$];
  longint         sum_cyc[$];

  always @(posedge clk_i) begin
    bit acc;
    cyc++;
    m_acc = 0;
    if (rst_i) begin
      started = 1; m_bubble = 0; part.delete(); m_vec = '0;
      m_vid = '0; m_next = '0; sumq.delete();
    end else begin
      acc = !m_bubble && st.s_valid_i;
      m_bubble = 0;
      if (acc) begin
        m_acc = 1;
        for (int l = 0; l < LANES; l++) part.push_back(st.s_data_i[l]);
        if (st.s_last_i || part.size() == ELEMS) begin
          m_vec = '0;
          for (int k = 0; k < part.size(); k++) m_vec[k] = part[k];
          part.delete();
          m_vid = m_next;
          m_next++;
          m_bubble = 1;
          sumq.push_back('{cyc + TL, m_vid});
        end
      end
    end
  end

  always @(negedge clk_i) begin
    bit exp_sum;
    if (started) begin
      chk("s_ready", st.s_ready_o, !rst_i && !m_bubble);
      chk("vec_valid", vec_valid_o, m_bubble);
      chk("vec_o", vec_o, m_vec);
      chk("vec_id", vec_id_o, m_vid);
      while (sumq.size() > 0 && sumq[0].due < cyc) void'(sumq.pop_front());
      exp_sum = sumq.size() > 0 && sumq[0].due == cyc;
      chk("sum_valid", sum_valid_o, exp_sum);
      if (exp_sum) begin
        chk("sum_id", sum_id_o, sumq[0].id);
        void'(sumq.pop_front());
      end
      if (sum_valid_o) sum_cyc.push_back(cyc);
    end
  end

  function automatic logic [BW-1:0] val(input row_t r, input int k);
    return r.konst ? r.base : BW'(int'(r.base) + k);
  endfunction

  // Holds the beat until the model reports it accepted; returns at posedge+2.
  task automatic drive_beat(input beat_t d, input logic last);
    bit ok = 0;
    st.s_valid_i = 1'b1; st.s_data_i = d; st.s_last_i = last;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(posedge clk_i); #2;
      ok = m_acc;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL beat_accept_timeout act=0 exp=1");
    end
    st.s_valid_i = 1'b0; st.s_last_i = 1'b0;
  endtask

  function automatic beat_t rnd_beat();
    beat_t d;
    for (int l = 0; l < LANES; l++) d[l] = BW'($urandom);
    return d;
  endfunction

  task automatic pulse_reset();
    rst_i = 1'b1; st.s_valid_i = 1'b0;
    @(posedge clk_i); #2;
    rst_i = 1'b0;
  endtask

  initial begin
    row_t rows[5];
    vec_t exp;
    beat_t d;
    row_t r;
    rows[0] = '{8, 1'b1, 1'b0, 8'h01, 32, 4'd0};
    rows[1] = '{3, 1'b1, 1'b1, 8'h3C, 12, 4'd1};
    rows[2] = '{1, 1'b1, 1'b0, 8'h01,  4, 4'd2};
    rows[3] = '{8, 1'b0, 1'b0, 8'h40, 32, 4'd3};
    rows[4] = '{5, 1'b1, 1'b1, 8'hFF, 20, 4'd4};

    st.s_valid_i = 1'b0; st.s_last_i = 1'b0; st.s_data_i = '0; rst_i = 1'b1;
    repeat (3) @(posedge clk_i); #2;
    chk("rst_ready", st.s_ready_o, 0);
    chk("rst_vec", vec_o, 0);
    chk("rst_vvalid", vec_valid_o, 0);
    chk("rst_sum", sum_valid_o, 0);
    rst_i = 1'b0;

    // Back-to-back table vectors; each next vector's first beat waits out the bubble.
    foreach (rows[i]) begin
      r = rows[i];
      for (int b = 0; b < r.nbeats; b++) begin
        for (int l = 0; l < LANES; l++) d[l] = val(r, b*LANES + l);
        drive_beat(d, r.use_last && (b == r.nbeats - 1));
      end
      exp = '0;
      for (int k = 0; k < r.exp_live; k++) exp[k] = val(r, k);
      chk("tbl_vvalid", vec_valid_o, 1);
      chk("tbl_ready", st.s_ready_o, 0);
      chk("tbl_vec", vec_o, exp);
      chk("tbl_id", vec_id_o, r.exp_id);
    end

    // Continuous valid: three full vectors, sums spaced BEATS+1 apart.
    pulse_reset();
    sum_cyc.delete();
    for (int i = 0; i < 3*BEATS; i++) drive_beat(rnd_beat(), 1'b0);
    repeat (TL + 12) @(posedge clk_i);
    #2;
    chk("cont_nsum", sum_cyc.size(), 3);
    if (sum_cyc.size() >= 3) begin
      chk("cont_gap1", sum_cyc[1] - sum_cyc[0], BEATS + 1);
      chk("cont_gap2", sum_cyc[2] - sum_cyc[1], BEATS + 1);
    end

    // Partial vector discarded by reset; the next short vector must be clean.
    for (int i = 0; i < 5; i++) drive_beat(rnd_beat(), 1'b0);
    pulse_reset();
    for (int b = 0; b < 2; b++) begin
      for (int l = 0; l < LANES; l++) d[l] = BW'(8'h80 + b*LANES + l);
      drive_beat(d, b == 1);
    end
    exp = '0;
    for (int k = 0; k < 2*LANES; k++) exp[k] = BW'(8'h80 + k);
    chk("rst_vec_after", vec_o, exp);
    chk("rst_id_after", vec_id_o, 0);
    sum_cyc.delete();
    repeat (3) @(posedge clk_i);
    #2;
    pulse_reset();
    repeat (TL + 5) @(posedge clk_i);
    #2;
    chk("flush_nsum", sum_cyc.size(), 0);

    // ID wrap: 16 single-beat vectors, the 17th carries ID 0 again.
    for (int i = 0; i < 17; i++) drive_beat(rnd_beat(), 1'b1);
    chk("wrap_vvalid", vec_valid_o, 1);
    chk("wrap_id", vec_id_o, 0);

    // Random gaps and random last, checked by the model every cycle.
    for (int i = 0; i < 400; i++) begin
      while ($urandom_range(1, 0) == 1) begin
        @(posedge clk_i); #2;
      end
      drive_beat(rnd_beat(), $urandom_range(6, 0) == 0);
    end
    repeat (TL + 5) @(posedge clk_i);
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
